// File: rtl/uart_tx_feeder_if.sv
`timescale 1ns/1ps
// Host write port and transmitter handshake of uart_tx_feeder, bundled as one interface.
interface uart_tx_feeder_if #(
  parameter int ADDR_W = 4
) ();
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_en;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              tx_done;

  modport master (
    output wr_en, wr_data, tx_busy, tx_done,
    input  full, empty, count, overflow, tx_en, tx_data
  );

  modport slave (
    input  wr_en, wr_data, tx_busy, tx_done,
    output full, empty, count, overflow, tx_en, tx_data
  );
endinterface

// File: rtl/uart_tx_feeder.sv
`timescale 1ns/1ps
// uart_tx_feeder: byte FIFO that hands one byte at a time to a UART transmitter.
// Define UART_FEEDER_GAP_EN to insert GAP_CYCLES idle clocks between frames.
module uart_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 16
) (
  input logic             clk,
  input logic             rst,
  uart_tx_feeder_if.slave bus
);

  if (DEPTH != (1 << ADDR_W) || GAP_CYCLES < 1) begin : g_param_check
    $error("uart_tx_feeder: DEPTH must equal 2**ADDR_W and GAP_CYCLES must be positive");
  end

  localparam logic [ADDR_W:0] FullCount = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
`ifdef UART_FEEDER_GAP_EN
    , GAP
`endif
  } state_t;

`ifdef UART_FEEDER_GAP_EN
  localparam state_t FrameEnd = GAP;
`else
  localparam state_t FrameEnd = IDLE;
`endif

  state_t            state;
  state_t            next_state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_next;
  logic              full_q;
  logic              empty_q;
  logic              pop;
  logic              wr_accept;
  logic              tx_en_q;
  logic [7:0]        tx_data_q;

  // A full FIFO still takes a write in the LAUNCH cycle because the head leaves on the same edge.
  assign pop       = (state == LAUNCH);
  assign wr_accept = bus.wr_en && (!full_q || pop);

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = bus.wr_en && full_q && !pop;
  assign bus.tx_en    = tx_en_q;
  assign bus.tx_data  = tx_data_q;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_comb begin
    count_next = count_q;
    case ({wr_accept, pop})
      2'b10:   count_next = count_q + 1'b1;
      2'b01:   count_next = count_q - 1'b1;
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_next;
      full_q  <= (count_next == FullCount);
      empty_q <= (count_next == '0);
    end
  end

`ifdef UART_FEEDER_GAP_EN
  localparam int GapW = $clog2(GAP_CYCLES + 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  logic [GapW-1:0] gap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (state == GAP && gap_cnt != GapLast) begin
      gap_cnt <= gap_cnt + 1'b1;
    end else begin
      gap_cnt <= '0;
    end
  end
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!empty_q && !bus.tx_busy) begin
          next_state = LAUNCH;
        end
      end
      LAUNCH: begin
        next_state = WAIT_BUSY;
      end
      // A transmitter that finishes before busy is seen still ends the frame here.
      WAIT_BUSY: begin
        if (bus.tx_done) begin
          next_state = FrameEnd;
        end else if (bus.tx_busy) begin
          next_state = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          next_state = FrameEnd;
        end
      end
`ifdef UART_FEEDER_GAP_EN
      GAP: begin
        if (gap_cnt == GapLast) begin
          next_state = IDLE;
        end
      end
`endif
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state   <= next_state;
      tx_en_q <= (next_state == LAUNCH);
      if (next_state == LAUNCH) begin
        tx_data_q <= mem[rd_ptr];
      end
    end
  end

endmodule
